// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the FP ALU operation sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // 65-bit command as buffered in the FIFO
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              op;
  } cmd_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command-in / result-out handshake bundle of the ALU operation sequencer.
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_op;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_carry;
  logic              out_op;

  // Producer/consumer side
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_op
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_op
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; a full FIFO never accepts, even on a same-cycle pop.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output cmd_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the combinational FP ALU: buffers commands, drives the ALU,
// waits a settle window, captures the result and offers it on a valid/ready port.
// Optional feature macro: ALU_SEQ_STICKY_EN (sticky carry/overflow flag).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               alu_selector,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_carry,
  output logic               busy
`ifdef ALU_SEQ_STICKY_EN
  ,
  output logic               sticky_carry,
  input  logic               sticky_clr
`endif
);

  state_t            state;
  logic [CNT_W-1:0]  settle_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              capture;
  cmd_t              push_cmd;
  cmd_t              head;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_result_q;
  logic              out_carry_q;
  logic              out_op_q;

  assign bus.in_ready   = rst_n && !fifo_full;
  assign push           = bus.in_valid && bus.in_ready;
  assign push_cmd       = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
  assign pop            = !fifo_empty &&
                          ((state == IDLE) || ((state == HOLD) && bus.out_ready));
  assign capture        = (state == DRIVE) && (settle_cnt == '0);
  assign busy           = (state != IDLE) || !fifo_empty;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_op     = out_op_q;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // ALU operand registers and settle counter, loaded only on a pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_selector <= 1'b0;
      settle_cnt   <= '0;
    end else if (pop) begin
      alu_a        <= head.a;
      alu_b        <= head.b;
      alu_selector <= head.op;
      settle_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
    end else if ((state == DRIVE) && (settle_cnt != '0)) begin
      settle_cnt   <= settle_cnt - 1'b1;
    end
  end

  // Sequencing FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_op_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) state <= DRIVE;
        end
        DRIVE: begin
          if (capture) begin
            out_result_q <= alu_result;
            out_carry_q  <= alu_carry;
            out_op_q     <= alu_selector;
            out_valid_q  <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= pop ? DRIVE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_EN
  // Sticky overflow flag; a new carry capture wins over a clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_carry <= 1'b0;
    end else if (capture && alu_carry) begin
      sticky_carry <= 1'b1;
    end else if (sticky_clr) begin
      sticky_carry <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural FP ALU model.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst3_n;

  alu_op_sequencer_if bus1 ();
  alu_op_sequencer_if bus3 ();

  logic [31:0] alu_a1, alu_b1, alu_res1;
  logic        alu_sel1, alu_cy1, busy1;
  logic [31:0] alu_a3, alu_b3, alu_res3;
  logic        alu_sel3, alu_cy3, busy3;
`ifdef ALU_SEQ_STICKY_EN
  logic sticky1, sticky_clr1, sticky3;
`endif

  // Behavioural ALU: exact results for the operand pairs used here
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    if (op == OP_MUL && a == 32'h40000000 && b == 32'h40400000) return {1'b0, 32'h40C00000};
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h3F800000) return {1'b0, 32'h40000000};
    if (op == OP_MUL && a == 32'h40000000 && b == 32'h40000000) return {1'b0, 32'h40800000};
    if (op == OP_ADD && a == 32'hBF800000 && b == 32'h3F800000) return {1'b0, 32'h00000000};
    if (op == OP_MUL && a == 32'h7F000000 && b == 32'h7F000000) return {1'b1, 32'h7F800000};
    return {1'b0, a + b};
  endfunction

  assign {alu_cy1, alu_res1} = alu_model(alu_a1, alu_b1, alu_sel1);
  assign {alu_cy3, alu_res3} = alu_model(alu_a3, alu_b3, alu_sel3);

  alu_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus1.slave),
    .alu_a        (alu_a1),
    .alu_b        (alu_b1),
    .alu_selector (alu_sel1),
    .alu_result   (alu_res1),
    .alu_carry    (alu_cy1),
    .busy         (busy1)
`ifdef ALU_SEQ_STICKY_EN
    ,
    .sticky_carry (sticky1),
    .sticky_clr   (sticky_clr1)
`endif
  );

  alu_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3)) u_dut3 (
    .clk          (clk),
    .rst_n        (rst3_n),
    .bus          (bus3.slave),
    .alu_a        (alu_a3),
    .alu_b        (alu_b3),
    .alu_selector (alu_sel3),
    .alu_result   (alu_res3),
    .alu_carry    (alu_cy3),
    .busy         (busy3)
`ifdef ALU_SEQ_STICKY_EN
    ,
    .sticky_carry (sticky3),
    .sticky_clr   (1'b0)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp_res;
    logic        exp_cy;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t        vecs [6];
  logic [31:0] res_q [$];
  int          cyc_q [$];
  int          n_valid;

  initial begin
    vecs[0] = '{32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 1'b0};
    vecs[1] = '{32'h40000000, 32'h40400000, OP_MUL, 32'h40C00000, 1'b0};
    vecs[2] = '{32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000, 1'b0};
    vecs[3] = '{32'h40000000, 32'h40000000, OP_MUL, 32'h40800000, 1'b0};
    vecs[4] = '{32'hBF800000, 32'h3F800000, OP_ADD, 32'h00000000, 1'b0};
    vecs[5] = '{32'h7F000000, 32'h7F000000, OP_MUL, 32'h7F800000, 1'b1};

    rst_n = 1'b0; rst3_n = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_op = 1'b0; bus1.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_a = '0; bus3.in_b = '0; bus3.in_op = 1'b0; bus3.out_ready = 1'b0;
`ifdef ALU_SEQ_STICKY_EN
    sticky_clr1 = 1'b0;
`endif
    tick();
    tick();
    check("in_ready low in reset", 64'(bus1.in_ready), 64'd0);
    rst_n = 1'b1; rst3_n = 1'b1;
    #1;
    check("reset out_valid", 64'(bus1.out_valid), 64'd0);
    check("reset busy", 64'(busy1), 64'd0);
    check("reset in_ready", 64'(bus1.in_ready), 64'd1);
    check("reset alu_a", 64'(alu_a1), 64'd0);
    check("reset out_result", 64'(bus1.out_result), 64'd0);
    check("reset3 out_valid", 64'(bus3.out_valid), 64'd0);
    check("reset3 busy", 64'(busy3), 64'd0);
`ifdef ALU_SEQ_STICKY_EN
    check("reset sticky", 64'(sticky1), 64'd0);
`endif

    // Table-driven single transactions, SETTLE_CYCLES = 1
    for (int i = 0; i < 6; i++) begin
      bus1.in_a = vecs[i].a; bus1.in_b = vecs[i].b; bus1.in_op = vecs[i].op;
      bus1.in_valid = 1'b1;
      check($sformatf("v%0d in_ready", i), 64'(bus1.in_ready), 64'd1);
      tick();  // E0: accept
      bus1.in_valid = 1'b0;
      check($sformatf("v%0d busy after accept", i), 64'(busy1), 64'd1);
      check($sformatf("v%0d no early valid", i), 64'(bus1.out_valid), 64'd0);
      tick();  // E1: pop and drive
      check($sformatf("v%0d alu_a", i), 64'(alu_a1), 64'(vecs[i].a));
      check($sformatf("v%0d alu_b", i), 64'(alu_b1), 64'(vecs[i].b));
      check($sformatf("v%0d alu_selector", i), 64'(alu_sel1), 64'(vecs[i].op));
      check($sformatf("v%0d valid at E1", i), 64'(bus1.out_valid), 64'd0);
      tick();  // E2: capture
      check($sformatf("v%0d out_valid", i), 64'(bus1.out_valid), 64'd1);
      check($sformatf("v%0d out_result", i), 64'(bus1.out_result), 64'(vecs[i].exp_res));
      check($sformatf("v%0d out_carry", i), 64'(bus1.out_carry), 64'(vecs[i].exp_cy));
      check($sformatf("v%0d out_op", i), 64'(bus1.out_op), 64'(vecs[i].op));
      tick();  // held without out_ready
      check($sformatf("v%0d held valid", i), 64'(bus1.out_valid), 64'd1);
      check($sformatf("v%0d held result", i), 64'(bus1.out_result), 64'(vecs[i].exp_res));
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      check($sformatf("v%0d valid cleared", i), 64'(bus1.out_valid), 64'd0);
      check($sformatf("v%0d idle busy", i), 64'(busy1), 64'd0);
    end

    // Back-to-back with out_ready held high
    bus1.out_ready = 1'b1;
    bus1.in_a = 32'h40000000; bus1.in_b = 32'h40400000; bus1.in_op = OP_MUL;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_a = 32'h3F800000; bus1.in_b = 32'h3F800000; bus1.in_op = OP_ADD;
    check("b2b second in_ready", 64'(bus1.in_ready), 64'd1);
    tick();
    bus1.in_valid = 1'b0;
    res_q.delete(); cyc_q.delete();
    for (int c = 0; c < 12; c++) begin
      if (bus1.out_valid && bus1.out_ready) begin
        res_q.push_back(bus1.out_result);
        cyc_q.push_back(c);
      end
      tick();
    end
    check("b2b result count", 64'(res_q.size()), 64'd2);
    if (res_q.size() == 2) begin
      check("b2b first result", 64'(res_q[0]), 64'h40C00000);
      check("b2b second result", 64'(res_q[1]), 64'h40000000);
      check("b2b spacing", 64'(cyc_q[1] - cyc_q[0]), 64'd2);
    end
    bus1.out_ready = 1'b0;

    // Backpressure: fill HOLD plus four queued entries
    for (int i = 0; i < 5; i++) begin
      bus1.in_a = 32'h100 + 32'(i); bus1.in_b = 32'h1; bus1.in_op = OP_ADD;
      bus1.in_valid = 1'b1;
      check($sformatf("bp push%0d in_ready", i), 64'(bus1.in_ready), 64'd1);
      tick();
    end
    bus1.in_a = 32'h200; bus1.in_b = 32'h1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp full in_ready c%0d", c), 64'(bus1.in_ready), 64'd0);
      check($sformatf("bp stable result c%0d", c), 64'(bus1.out_result), 64'h101);
      check($sformatf("bp stable valid c%0d", c), 64'(bus1.out_valid), 64'd1);
      tick();
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    res_q.delete();
    for (int c = 0; c < 40; c++) begin
      if (bus1.out_valid && bus1.out_ready) res_q.push_back(bus1.out_result);
      tick();
    end
    bus1.out_ready = 1'b0;
    check("bp drain count", 64'(res_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < res_q.size())
        check($sformatf("bp drain %0d", i), 64'(res_q[i]), 64'h101 + 64'(i));
    end
    check("bp drained busy", 64'(busy1), 64'd0);
    check("bp drained in_ready", 64'(bus1.in_ready), 64'd1);

    // SETTLE_CYCLES = 3 latency
    bus3.in_a = 32'h3F800000; bus3.in_b = 32'h40000000; bus3.in_op = OP_ADD;
    bus3.in_valid = 1'b1;
    tick();
    bus3.in_valid = 1'b0;
    tick();
    check("s3 alu_a at E1", 64'(alu_a3), 64'h3F800000);
    check("s3 valid at E1", 64'(bus3.out_valid), 64'd0);
    tick();
    check("s3 valid at E2", 64'(bus3.out_valid), 64'd0);
    tick();
    check("s3 valid at E3", 64'(bus3.out_valid), 64'd0);
    tick();
    check("s3 valid at E4", 64'(bus3.out_valid), 64'd1);
    check("s3 result", 64'(bus3.out_result), 64'h40400000);
    bus3.out_ready = 1'b1;
    tick();
    bus3.out_ready = 1'b0;
    check("s3 valid cleared", 64'(bus3.out_valid), 64'd0);

    // Reset in the middle of DRIVE with a second command queued
    bus3.in_a = 32'h40000000; bus3.in_b = 32'h40400000; bus3.in_op = OP_MUL;
    bus3.in_valid = 1'b1;
    tick();
    bus3.in_a = 32'h3F800000; bus3.in_b = 32'h3F800000; bus3.in_op = OP_ADD;
    tick();
    bus3.in_valid = 1'b0;
    check("rst pre busy", 64'(busy3), 64'd1);
    rst3_n = 1'b0;
    #1;
    check("rst in_ready forced low", 64'(bus3.in_ready), 64'd0);
    tick();
    rst3_n = 1'b1;
    #1;
    check("rst out_valid", 64'(bus3.out_valid), 64'd0);
    check("rst busy", 64'(busy3), 64'd0);
    check("rst in_ready", 64'(bus3.in_ready), 64'd1);
    check("rst alu_a", 64'(alu_a3), 64'd0);
    check("rst alu_selector", 64'(alu_sel3), 64'd0);
    bus3.out_ready = 1'b1;
    n_valid = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus3.out_valid) n_valid++;
      tick();
    end
    bus3.out_ready = 1'b0;
    check("rst discarded commands", 64'(n_valid), 64'd0);
    check("rst busy stays low", 64'(busy3), 64'd0);

`ifdef ALU_SEQ_STICKY_EN
    // Sticky flag: clear, set by overflow, hold, clear, and set-wins-over-clear
    sticky_clr1 = 1'b1;
    tick();
    sticky_clr1 = 1'b0;
    check("sticky cleared", 64'(sticky1), 64'd0);
    bus1.in_a = 32'h7F000000; bus1.in_b = 32'h7F000000; bus1.in_op = OP_MUL;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    tick();
    check("sticky out_carry", 64'(bus1.out_carry), 64'd1);
    check("sticky set", 64'(sticky1), 64'd1);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    tick();
    tick();
    check("sticky held", 64'(sticky1), 64'd1);
    sticky_clr1 = 1'b1;
    tick();
    sticky_clr1 = 1'b0;
    check("sticky clr pulse", 64'(sticky1), 64'd0);
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    sticky_clr1 = 1'b1;
    tick();
    sticky_clr1 = 1'b0;
    check("sticky coincident valid", 64'(bus1.out_valid), 64'd1);
    check("sticky set wins", 64'(sticky1), 64'd1);
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
